// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 4-channel TDM demultiplexer.
//   state_t : frame-alignment state (HUNT = unaligned, LOCK = aligned)
//   NSLOT   : number of TDM slots / channels
//   SLOT_W  : width of the slot counter
package tdm_pkg;

    typedef enum logic {
        HUNT,
        LOCK
    } state_t;

    localparam int NSLOT  = 4;
    localparam int SLOT_W = 2;

endpackage

// File: rtl/tdm_chan_acc.sv
// tdm_chan_acc: per-channel word accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : discard the partial word
//   cap        : shift d into the partial word this cycle
//   last       : this capture completes the word
//   d          : serial bit
//   word       : last completed word, held until the next completion
//   wv         : one-cycle pulse when word is updated
module tdm_chan_acc #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         cap,
    input  logic         last,
    input  logic         d,
    output logic [W-1:0] word,
    output logic         wv
);

    logic [W-1:0] sr;
    logic [W-1:0] sr_base;
    logic [W-1:0] sr_next;

    // A capture coinciding with clr starts a fresh word from this bit.
    always_comb begin
        sr_base = clr ? '0 : sr;
        if (MSB_FIRST) begin
            sr_next = {sr_base[W-2:0], d};
        end else begin
            sr_next = {d, sr_base[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            word <= '0;
            wv   <= 1'b0;
        end else begin
            wv <= 1'b0;
            if (cap) begin
                sr <= sr_next;
                wv <= last;
                if (last) begin
                    word <= sr_next;
                end
            end else if (clr) begin
                sr <= '0;
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-channel TDM demultiplexer with frame-sync lock.
//   clk, rst_n : clock, asynchronous active-low reset
//   e          : active-low enable (1 = stall)
//   sync       : frame marker, high with the slot-0 bit
//   d          : serial TDM data
//   y          : registered demux bit, y[k] = d for the slot captured
//   ystb       : one-hot strobe of the slot captured last cycle
//   q          : channel words, channel k at q[k*W +: W]
//   qv         : per-channel word-valid pulse
//   err        : one-cycle pulse on a sync violation
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic             sync,
    input  logic             d,
    output logic [NSLOT-1:0] y,
    output logic [NSLOT-1:0] ystb,
    output logic [NSLOT*W-1:0] q,
    output logic [NSLOT-1:0] qv,
    output logic             err
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0]     LAST_BIT  = CW'(W - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [CW-1:0]     bitcnt;

    logic [NSLOT-1:0]  cap_ch;
    logic              cap_last;
    logic              clr_all;
    logic              viol;

    // Capture decode for the current enabled cycle.
    always_comb begin
        cap_ch   = '0;
        cap_last = 1'b0;
        clr_all  = 1'b0;
        viol     = 1'b0;
        if (!e) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        cap_ch[0] = 1'b1;
                        clr_all   = 1'b1;
                    end
                end
                LOCK: begin
                    if (slot == '0) begin
                        if (sync) begin
                            cap_ch[0] = 1'b1;
                            cap_last  = (bitcnt == LAST_BIT);
                        end else begin
                            viol    = 1'b1;
                            clr_all = 1'b1;
                        end
                    end else if (sync) begin
                        // Early sync: restart the frame with this bit as ch0 bit 0.
                        viol      = 1'b1;
                        clr_all   = 1'b1;
                        cap_ch[0] = 1'b1;
                    end else begin
                        cap_ch[slot] = 1'b1;
                        cap_last     = (bitcnt == LAST_BIT);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            slot   <= '0;
            bitcnt <= '0;
            y      <= '0;
            ystb   <= '0;
            err    <= 1'b0;
        end else begin
            ystb <= cap_ch;
            y    <= cap_ch & {NSLOT{d}};
            err  <= viol;
            if (!e) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            state  <= LOCK;
                            slot   <= SLOT_W'(1);
                            bitcnt <= '0;
                        end
                    end
                    LOCK: begin
                        if (viol) begin
                            bitcnt <= '0;
                            if (sync) begin
                                slot <= SLOT_W'(1);
                            end else begin
                                state <= HUNT;
                                slot  <= '0;
                            end
                        end else begin
                            slot <= slot + 1'b1;
                            if (slot == LAST_SLOT) begin
                                bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NSLOT; k++) begin : g_ch
        tdm_chan_acc #(
            .W         (W),
            .MSB_FIRST (MSB_FIRST)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_all),
            .cap   (cap_ch[k]),
            .last  (cap_last),
            .d     (d),
            .word  (q[k*W +: W]),
            .wv    (qv[k])
        );
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: randomized and directed checks of tdm_demux4 against a
// queue-based frame model.
module tb_tdm_demux4;

    localparam int W         = 8;
    localparam bit MSB_FIRST = 1'b1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         e;
    logic         sync;
    logic         d;
    logic [3:0]   y;
    logic [3:0]   ystb;
    logic [4*W-1:0] q;
    logic [3:0]   qv;
    logic         err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit             m_lock;
    int             pos;          // bit index within the 4*W-bit frame group
    bit             chq [4][$];   // bits received so far per channel
    logic [3:0]     ey, estb, eqv;
    logic           eerr;
    logic [4*W-1:0] eq;

    tdm_demux4 #(.W(W), .MSB_FIRST(MSB_FIRST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .sync  (sync),
        .d     (d),
        .y     (y),
        .ystb  (ystb),
        .q     (q),
        .qv    (qv),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("y",    32'(y),    32'(ey));
        chk("ystb", 32'(ystb), 32'(estb));
        chk("qv",   32'(qv),   32'(eqv));
        chk("err",  32'(err),  32'(eerr));
        chk("q",    32'(q),    32'(eq));
    endtask

    task automatic m_clear();
        for (int k = 0; k < 4; k++) chq[k].delete();
        pos = 0;
    endtask

    task automatic m_reset();
        m_lock = 1'b0;
        m_clear();
        ey = '0; estb = '0; eqv = '0; eerr = 1'b0; eq = '0;
    endtask

    task automatic m_cap(input int k, input bit b);
        logic [W-1:0] w;
        w = '0;
        chq[k].push_back(b);
        ey[k]   = b;
        estb[k] = 1'b1;
        if (chq[k].size() == W) begin
            for (int i = 0; i < W; i++) begin
                if (MSB_FIRST) w[W-1-i] = chq[k][i];
                else           w[i]     = chq[k][i];
            end
            eq[k*W +: W] = w;
            eqv[k] = 1'b1;
            chq[k].delete();
        end
        pos = (pos + 1) % (4 * W);
    endtask

    task automatic step(input bit ie, input bit is, input bit id);
        int k;
        e = ie; sync = is; d = id;
        ey = '0; estb = '0; eqv = '0; eerr = 1'b0;
        if (!ie) begin
            if (!m_lock) begin
                if (is) begin
                    m_clear();
                    m_lock = 1'b1;
                    m_cap(0, id);
                end
            end else begin
                k = pos % 4;
                if (k == 0 && !is) begin
                    eerr = 1'b1;
                    m_clear();
                    m_lock = 1'b0;
                end else if (k != 0 && is) begin
                    eerr = 1'b1;
                    m_clear();
                    m_cap(0, id);
                end else begin
                    m_cap(k, id);
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [W-1:0] w2, input logic [W-1:0] w3,
                              input int stall_b);
        logic [W-1:0] wa [4];
        wa[0] = w0; wa[1] = w1; wa[2] = w2; wa[3] = w3;
        for (int b = 0; b < W; b++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, k == 0, MSB_FIRST ? wa[k][W-1-b] : wa[k][b]);
                if (b == stall_b && k == 1) begin
                    repeat (3) step(1'b1, 1'b1, 1'($urandom));
                end
            end
        end
    endtask

    task automatic chk_words(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2, input logic [W-1:0] w3);
        chk({tag, "_ch0"}, 32'(q[0*W +: W]), 32'(w0));
        chk({tag, "_ch1"}, 32'(q[1*W +: W]), 32'(w1));
        chk({tag, "_ch2"}, 32'(q[2*W +: W]), 32'(w2));
        chk({tag, "_ch3"}, 32'(q[3*W +: W]), 32'(w3));
    endtask

    initial begin
        bit s;
        rst_n = 1'b0; e = 1'b1; sync = 1'b0; d = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Lock and slot routing
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Asynchronous reset with a partial word pending
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Full words, then the same pattern style with a stall holding sync high
        send_words(8'hA5, 8'h3C, 8'hFF, 8'h00, -1);
        chk_words("words", 8'hA5, 8'h3C, 8'hFF, 8'h00);
        send_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 3);
        chk_words("stall", 8'hA5, 8'h3C, 8'hFF, 8'h00);

        // Missing sync at slot 0, then relock
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        send_words(8'h12, 8'h34, 8'h56, 8'h78, -1);
        chk_words("relock", 8'h12, 8'h34, 8'h56, 8'h78);

        // Sync arriving at slot 2 restarts the frame on that bit
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        send_words(8'h96, 8'h0F, 8'hE1, 8'h7E, -1);
        chk_words("early", 8'h96, 8'h0F, 8'hE1, 8'h7E);

        // Randomized traffic with occasional stalls and sync faults
        for (int i = 0; i < 3000; i++) begin
            s = m_lock ? (pos % 4 == 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) s = ~s;
            step(($urandom_range(0, 4) == 0), s, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

4-channel time-division demultiplexer: the receive-side counterpart of the team's 4:1 enabled mux, which interleaves four channels onto one bit line. It locks to a frame-sync marker, routes each serial bit to its slot's channel, and assembles W-bit words per channel with a one-cycle valid pulse. It sits between a serial TDM link and four parallel channel consumers.

## Interface
- W, default 8, bits per channel word (W ≥ 2)
- MSB_FIRST, default 1, 1: first received bit of a word lands in the MSB; 0: in the LSB
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- e  in  1  active-low enable; 1 = stall, nothing consumed
- sync  in  1  frame marker, high with the slot-0 bit of every frame
- d  in  1  serial TDM data, one bit per enabled cycle
- y  out  4  registered demux bit; y[k] = d for the current slot k, other bits 0
- ystb  out  4  one-hot strobe marking the slot routed last cycle
- q  out  4*W  channel words; channel k at q[k*W +: W]
- qv  out  4  qv[k] pulses one cycle when q[k*W +: W] is updated
- err  out  1  one-cycle pulse on a sync violation

## Operation
- States: HUNT (no alignment), LOCK (aligned).
- Slot counter `slot` runs 0..3. Frame counter `bitcnt` runs 0..W-1 and increments after slot 3.
- Enabled cycle = e==0. On cycles with e==1, no state, slot, bitcnt, or shift-register change occurs. On the next edge, y, ystb, qv, and err are driven to 0.
- HUNT
  - Enabled cycle with sync=1: the bit is slot 0 of frame 0. Capture into ch0, go to LOCK, slot←1.
  - Enabled cycle with sync=0: the bit is discarded.
- LOCK, enabled cycle
  - slot 0, sync=1: normal capture.
  - slot 0, sync=0: err pulse, bit discarded, all partial words and bitcnt cleared, go to HUNT.
  - slot≠0, sync=1: err pulse. Clear partials and bitcnt, treat this bit as slot 0 of frame 0, slot←1, stay in LOCK.
  - slot≠0, sync=0: capture into channel `slot`, slot←slot+1 mod 4.
- Capture into channel k:
  - The per-channel shift register shifts in d (left if MSB_FIRST, right otherwise).
  - y[k]←d and ystb[k]←1 next cycle.
- Word completion:
  - When bitcnt==W-1 and channel k captures, the full word is loaded into q[k*W +: W] next cycle and qv[k]=1 for that cycle.
  - q holds its value until the next completion for that channel.
  - The four qv pulses appear on four consecutive enabled-capture cycles, never simultaneously.
- The shift-register value is replaced, not accumulated, across words. There is no overflow: bitcnt wraps W-1→0 after slot 3.

## Timing
- Reset (async assert, synchronous deassert by the upstream synchronizer):
  - State HUNT; slot, bitcnt, and all shift registers 0.
  - y=0, ystb=0, q=0, qv=0, err=0.
- Reset mid-frame discards all partials immediately.
- Latency: d sampled at edge n → y/ystb valid after edge n.
- Last bit of a word sampled at edge n → q/qv valid after edge n.
- err asserts after the violating edge, for exactly one cycle.
- y, ystb, qv, and err are single-cycle values; they are 0 on any cycle not following an enabled capture or violation.
- sync with e=1 is ignored.

## Structure
- Package tdm_pkg:
  - state enum {HUNT, LOCK}
  - NSLOT=4
  - SLOT_W=2
- Sub-module tdm_chan_acc (parameters W, MSB_FIRST), instantiated 4×:
  - Inputs: clk, rst_n, clr, cap, last, d.
  - Outputs: word, wv.
  - Holds the shift register and q/qv registers.
- Top level holds the FSM, slot/bitcnt counters, y/ystb/err registers, and the capture decode.

## Test plan
- Reset: assert rst_n=0 mid-LOCK with a partial word → all outputs 0 asynchronously. After release, d ignored until sync.
- Lock: e=0, sync=1 on the first bit, d sequence 1,0,1,1 → ystb 0001,0010,0100,1000 and y 0001,0000,0100,1000 on the following four cycles.
- Words, W=8, MSB_FIRST=1: send 0xA5, 0x3C, 0xFF, 0x00 interleaved over 8 frames with sync each frame → qv 0001,0010,0100,1000 on consecutive cycles, with q ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x00.
- Stall: e=1 for 3 cycles between slots 1 and 2, with sync=1 during the stall → y/ystb/qv stay 0 and there is no err. Resulting words are identical to the unstalled run.
- Missing sync at slot 0 → err=1 for one cycle, HUNT, no qv. The next sync relocks and a full word completes correctly.
- Sync at slot 2 → err pulse, that bit becomes ch0 bit 0, and the partial ch1 word is discarded. Eight subsequent frames yield correct words.
